// File: rtl/led_pwm_multichannel.sv
// Multi-channel LED PWM driver: CHANNELS outputs share one free-running period counter,
// with double-buffered duty values that only take effect at the period boundary.
module led_pwm_multichannel #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 10,
   parameter int STAGGER  = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] data,
   input  logic                      load,
   input  logic                      enable,
   output logic [CHANNELS-1:0]       out,
   output logic                      period_start,
   output logic                      pending
);

   localparam int unsigned PERIOD = 32'd1 << WIDTH;
   localparam int unsigned STEP   = (CHANNELS > 32'sd0) ? PERIOD / $unsigned(CHANNELS) : 32'd0;

   if (CHANNELS < 32'sd1 || CHANNELS > 32'sd8) begin : g_bad_channels
      $error("led_pwm_multichannel: CHANNELS must be in 1..8");
   end
   if (WIDTH < 32'sd4 || WIDTH > 32'sd12) begin : g_bad_width
      $error("led_pwm_multichannel: WIDTH must be in 4..12");
   end

   // Offset of a channel's phase counter; wraps naturally by truncation to WIDTH bits.
   function automatic logic [WIDTH-1:0] phase_offset(input int ch);
      logic [31:0] off;
      off = (STAGGER != 32'sd0) ? $unsigned(ch) * STEP : 32'd0;
      return off[WIDTH-1:0];
   endfunction

   logic [WIDTH-1:0]          cnt_q, cnt_d;
   logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
   logic [CHANNELS*WIDTH-1:0] active_q, active_d;
   logic                      pending_q, pending_d;
   logic [CHANNELS-1:0]       out_q, out_d;
   logic                      period_start_q, period_start_d;
   logic                      boundary_s;
   logic [WIDTH-1:0]          pc_s [CHANNELS];

   // Next-state logic: counter, duty double-buffering and per-channel compare.
   always_comb begin
      cnt_d          = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      boundary_s     = (cnt_q == {WIDTH{1'b1}});
      shadow_d       = shadow_q;
      active_d       = active_q;
      pending_d      = pending_q;
      out_d          = {CHANNELS{1'b0}};
      pc_s           = '{default: {WIDTH{1'b0}}};
      period_start_d = (cnt_q == {WIDTH{1'b0}});

      if (load) begin
         shadow_d = data;
         if (boundary_s) begin
            active_d  = data;
            pending_d = 1'b0;
         end else begin
            pending_d = 1'b1;
         end
      end else if (boundary_s && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      for (int ch = 0; ch < CHANNELS; ch++) begin
         pc_s[ch]  = cnt_q + phase_offset(ch);
         out_d[ch] = enable & (pc_s[ch] < active_q[ch*WIDTH +: WIDTH]);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= {WIDTH{1'b0}};
         shadow_q       <= {(CHANNELS*WIDTH){1'b0}};
         active_q       <= {(CHANNELS*WIDTH){1'b0}};
         pending_q      <= 1'b0;
         out_q          <= {CHANNELS{1'b0}};
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;
   assign pending      = pending_q;

endmodule
